// File: rtl/speed_test_frame_checker.sv
// Receive-side frame checker for one speed-test port: classifies test frames as good or
// errored against the configured length and incrementing payload pattern, and counts them.
module speed_test_frame_checker #(
    parameter int unsigned FRAME_LEN_W = 16,
    parameter int unsigned HDR_BYTES   = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    input  logic                   s_axis_tuser,
    output logic                   s_axis_tready,
    input  logic                   start,
    input  logic                   stop,
    input  logic [FRAME_LEN_W-1:0] cfg_frame_len,
    output logic                   ready,
    output logic [127:0]           result
);

    typedef enum logic [1:0] {StInit, StIdle, StActive} state_t;

    state_t                 state_q, state_d;
    logic                   start_d;
    logic                   tready_q;
    logic                   in_frame_q, in_frame_d;
    logic                   acc_q, acc_d;
    logic                   err_q, err_d;
    logic [FRAME_LEN_W-1:0] idx_q, idx_d;
    logic [FRAME_LEN_W-1:0] len_q, len_d;
    logic [31:0]            rx_frames_q, rx_frames_d;
    logic [31:0]            rx_bytes_q, rx_bytes_d;
    logic [31:0]            good_frames_q, good_frames_d;
    logic [31:0]            err_frames_q, err_frames_d;

    logic                   first_beat, start_rise, accept_now, frame_acc, beat_acc;
    logic [FRAME_LEN_W-1:0] idx, byte_cnt;
    logic                   beyond, pat_err, last_err, frame_err;
    logic [32:0]            bytes_sum;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    assign first_beat = s_axis_tvalid && !in_frame_q;
    assign start_rise = start && !start_d;
    assign accept_now = (state_q == StActive) && (start || stop);
    // Acceptance is decided on the first beat and carried for the rest of the frame.
    assign frame_acc  = first_beat ? accept_now : acc_q;
    assign beat_acc   = s_axis_tvalid && frame_acc;

    assign idx       = in_frame_q ? idx_q : '0;
    assign byte_cnt  = (&idx) ? idx : idx + 1'b1;
    assign beyond    = idx >= len_q;
    assign pat_err   = (idx >= FRAME_LEN_W'(HDR_BYTES)) && !beyond && (s_axis_tdata != idx[7:0]);
    assign last_err  = s_axis_tlast && ((byte_cnt != len_q) || s_axis_tuser);
    assign frame_err = err_q || beyond || pat_err || last_err;
    assign bytes_sum = {1'b0, rx_bytes_q} + 33'(byte_cnt);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StInit:   state_d = StIdle;
            StIdle:   if (start_rise) state_d = StActive;
            StActive: if (!start && !stop && !acc_q) state_d = StIdle;
            default:  state_d = StInit;
        endcase
    end

    always_comb begin
        in_frame_d = in_frame_q;
        acc_d      = acc_q;
        err_d      = err_q;
        idx_d      = idx_q;
        if (s_axis_tvalid) begin
            in_frame_d = !s_axis_tlast;
            acc_d      = s_axis_tlast ? 1'b0 : frame_acc;
            err_d      = s_axis_tlast ? 1'b0 : frame_err;
            idx_d      = s_axis_tlast ? '0 : byte_cnt;
        end
    end

    always_comb begin
        len_d         = len_q;
        rx_frames_d   = rx_frames_q;
        rx_bytes_d    = rx_bytes_q;
        good_frames_d = good_frames_q;
        err_frames_d  = err_frames_q;
        if (state_q == StIdle && start_rise) begin
            len_d         = cfg_frame_len;
            rx_frames_d   = '0;
            rx_bytes_d    = '0;
            good_frames_d = '0;
            err_frames_d  = '0;
        end else if (beat_acc && s_axis_tlast) begin
            rx_frames_d = sat_inc(rx_frames_q);
            rx_bytes_d  = bytes_sum[32] ? 32'hFFFF_FFFF : bytes_sum[31:0];
            if (frame_err) err_frames_d = sat_inc(err_frames_q);
            else           good_frames_d = sat_inc(good_frames_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StInit;
            start_d       <= 1'b0;
            tready_q      <= 1'b0;
            in_frame_q    <= 1'b0;
            acc_q         <= 1'b0;
            err_q         <= 1'b0;
            idx_q         <= '0;
            len_q         <= '0;
            rx_frames_q   <= '0;
            rx_bytes_q    <= '0;
            good_frames_q <= '0;
            err_frames_q  <= '0;
        end else begin
            state_q       <= state_d;
            start_d       <= start;
            tready_q      <= 1'b1;
            in_frame_q    <= in_frame_d;
            acc_q         <= acc_d;
            err_q         <= err_d;
            idx_q         <= idx_d;
            len_q         <= len_d;
            rx_frames_q   <= rx_frames_d;
            rx_bytes_q    <= rx_bytes_d;
            good_frames_q <= good_frames_d;
            err_frames_q  <= err_frames_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign ready         = (state_q == StIdle);
    assign result        = {err_frames_q, good_frames_q, rx_bytes_q, rx_frames_q};

endmodule

// File: tb/tb_speed_test_frame_checker.sv
// Bench for speed_test_frame_checker: a table of hand-classified frames, hand-written
// sequences for start/stop/reset corners, and random frames checked against a frame-level model.
module tb_speed_test_frame_checker;

    localparam int HDR = 14;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   s_axis_tdata;
    logic         s_axis_tvalid;
    logic         s_axis_tlast;
    logic         s_axis_tuser;
    logic         s_axis_tready;
    logic         start;
    logic         stop;
    logic [15:0]  cfg_frame_len;
    logic         ready;
    logic [127:0] result;

    speed_test_frame_checker #(.FRAME_LEN_W(16), .HDR_BYTES(HDR)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tready (s_axis_tready),
        .start         (start),
        .stop          (stop),
        .cfg_frame_len (cfg_frame_len),
        .ready         (ready),
        .result        (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int bad_idx;
        bit user;
        bit restart;
        bit good;
    } vec_t;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [7:0]  sent_q[$];
    logic [31:0] exp_frames, exp_bytes, exp_good, exp_err;
    int          cur_cfg;
    vec_t        tbl[20];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] sat_add(input logic [31:0] a, input longint unsigned b);
        longint unsigned s;
        s = longint'(a) + b;
        return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // Good means: exact configured length, no MAC error, payload bytes equal their index.
    function automatic bit frame_good(input int cfg, input bit user);
        if (sent_q.size() != cfg || user) return 1'b0;
        for (int i = HDR; i < cfg; i++)
            if (sent_q[i] != 8'(i)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic account(input bit good);
        exp_frames = sat_add(exp_frames, 1);
        exp_bytes  = sat_add(exp_bytes, sent_q.size());
        if (good) exp_good = sat_add(exp_good, 1);
        else      exp_err  = sat_add(exp_err, 1);
    endtask

    function automatic logic [127:0] exp_result();
        return {exp_err, exp_good, exp_bytes, exp_frames};
    endfunction

    task automatic model_clear();
        exp_frames = '0;
        exp_bytes  = '0;
        exp_good   = '0;
        exp_err    = '0;
    endtask

    task automatic drive_beat(input int i, input int len, input int bad_idx, input bit user);
        logic [7:0] b;
        b = (i < HDR) ? 8'($urandom) : 8'(i);
        if (i == bad_idx) b = b ^ 8'h5A;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = b;
        s_axis_tlast  = (i == len - 1);
        s_axis_tuser  = (i == len - 1) ? user : 1'($urandom);
        sent_q.push_back(b);
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic bubble();
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 8'($urandom);
        s_axis_tlast  = 1'($urandom);
        s_axis_tuser  = 1'($urandom);
        tick();
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
    endtask

    task automatic send_frame(input int len, input int bad_idx, input bit user, input bit gaps);
        sent_q.delete();
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) bubble();
            drive_beat(i, len, bad_idx, user);
        end
    endtask

    task automatic start_test(input int len);
        cur_cfg       = len;
        cfg_frame_len = 16'(len);
        start         = 1'b1;
        stop          = 1'b0;
        tick();
        model_clear();
        check("ready_active", 128'(ready), 128'(0));
        check("result_cleared", result, 128'(0));
    endtask

    task automatic end_test();
        start = 1'b0;
        stop  = 1'b0;
        tick();
        tick();
        check("ready_after_test", 128'(ready), 128'(1));
        tick();
        check("result_hold", result, exp_result());
    endtask

    initial begin
        rst = 1'b1; start = 1'b1; stop = 1'b0; cfg_frame_len = 16'd64;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
        model_clear();

        for (int k = 0; k < 10; k++) tbl[k] = '{64, -1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{64, 20, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{63, -1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{64, -1, 1'b1, 1'b0, 1'b0};
        tbl[13] = '{64, -1, 1'b0, 1'b0, 1'b1};
        tbl[14] = '{64, -1, 1'b0, 1'b0, 1'b1};
        tbl[15] = '{64, 14, 1'b0, 1'b0, 1'b0};
        tbl[16] = '{64, 63, 1'b0, 1'b0, 1'b0};
        tbl[17] = '{65, -1, 1'b0, 1'b0, 1'b0};
        tbl[18] = '{1,  -1, 1'b0, 1'b0, 1'b0};
        tbl[19] = '{64, 13, 1'b0, 1'b0, 1'b1};

        // Reset, with start held high across release.
        tick(); tick();
        check("rst_ready", 128'(ready), 128'(0));
        check("rst_tready", 128'(s_axis_tready), 128'(0));
        check("rst_result", result, 128'(0));
        rst = 1'b0;
        tick(); tick();
        check("idle_ready", 128'(ready), 128'(1));
        check("idle_tready", 128'(s_axis_tready), 128'(1));
        check("idle_result", result, 128'(0));
        start = 1'b0;
        tick();

        // Table-driven frames.
        start_test(64);
        for (int k = 0; k < 20; k++) begin
            if (tbl[k].restart) begin
                check("ten_good", result, {32'd0, 32'd10, 32'd640, 32'd10});
                end_test();
                start_test(64);
            end
            send_frame(tbl[k].len, tbl[k].bad_idx, tbl[k].user, k[0]);
            account(tbl[k].good);
            check($sformatf("tbl_%0d", k), result, exp_result());
            if (k == 14) check("mixed_five", result, {32'd3, 32'd2, 32'd319, 32'd5});
        end
        end_test();

        // Start falls and stop pulses mid-frame; exit waits for tlast.
        start_test(20);
        sent_q.delete();
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin start = 1'b0; stop = 1'b1; end
            if (i == 10) stop = 1'b0;
            drive_beat(i, 20, -1, 1'b0);
            if (i >= 10) check($sformatf("drain_ready_%0d", i), 128'(ready), 128'(0));
        end
        account(1'b1);
        check("drain_count", result, exp_result());
        tick();
        check("drain_exit", 128'(ready), 128'(1));
        send_frame(20, -1, 1'b0, 1'b0);
        check("idle_frame_ignored", result, exp_result());

        // Frame already in flight at the start rising edge is ignored.
        sent_q.delete();
        for (int i = 0; i < 20; i++) begin
            if (i == 10) start = 1'b1;
            drive_beat(i, 20, -1, 1'b0);
        end
        model_clear();
        check("partial_ignored", result, 128'(0));
        check("partial_active", 128'(ready), 128'(0));
        send_frame(20, -1, 1'b0, 1'b1);
        account(1'b1);
        check("after_partial", result, exp_result());
        end_test();

        // Counter saturation via backdoor preload.
        start_test(64);
        force dut.rx_frames_q   = 32'hFFFF_FFFE;
        force dut.rx_bytes_q    = 32'hFFFF_FF90;
        force dut.good_frames_q = 32'hFFFF_FFFE;
        force dut.err_frames_q  = 32'hFFFF_FFFE;
        #1;
        release dut.rx_frames_q;
        release dut.rx_bytes_q;
        release dut.good_frames_q;
        release dut.err_frames_q;
        exp_frames = 32'hFFFF_FFFE; exp_bytes = 32'hFFFF_FF90;
        exp_good   = 32'hFFFF_FFFE; exp_err   = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) begin
            send_frame(64, (k == 1) ? 30 : -1, 1'b0, 1'b0);
            account(k != 1);
            check($sformatf("sat_%0d", k), result, exp_result());
        end
        check("sat_final", result, {128{1'b1}});
        end_test();

        // Asynchronous reset mid-frame.
        start_test(32);
        sent_q.delete();
        for (int i = 0; i < 10; i++) drive_beat(i, 32, -1, 1'b0);
        s_axis_tvalid = 1'b1;
        rst = 1'b1;
        #2;
        check("midrst_result", result, 128'(0));
        check("midrst_ready", 128'(ready), 128'(0));
        check("midrst_tready", 128'(s_axis_tready), 128'(0));
        s_axis_tvalid = 1'b0;
        start = 1'b0;
        tick();
        rst = 1'b0;
        tick(); tick();
        start_test(32);
        send_frame(32, -1, 1'b0, 1'b0);
        account(1'b1);
        check("post_rst_frame", result, exp_result());
        end_test();

        // Randomized frames against the frame-level model.
        for (int t = 0; t < 6; t++) begin
            start_test($urandom_range(1, 40));
            for (int f = 0; f < 8; f++) begin
                int len, bad;
                bit user;
                len = cur_cfg; bad = -1; user = 1'b0;
                case ($urandom_range(0, 3))
                    1: bad = $urandom_range(0, cur_cfg - 1);
                    2: begin
                        len = cur_cfg + $urandom_range(0, 4) - 2;
                        if (len < 1) len = 1;
                    end
                    3: user = 1'b1;
                    default: ;
                endcase
                send_frame(len, bad, user, 1'b1);
                account(frame_good(cur_cfg, user));
                check($sformatf("rnd_%0d_%0d", t, f), result, exp_result());
            end
            end_test();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
